// File: rtl/cordic_hyp_sched_if.sv
// Requester-side bundle for the shared hyperbolic CORDIC scheduler:
// request handshake in, tagged result stream out.
interface cordic_hyp_sched_if #(
    parameter int NUM_REQ = 4,
    parameter int XY_SZ   = 16
);
    localparam int ID_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]    req_valid;
    logic [32*NUM_REQ-1:0] req_angle;
    logic [NUM_REQ-1:0]    req_ready;
    logic                  res_valid;
    logic [ID_W-1:0]       res_id;
    logic [XY_SZ:0]        res_cosh;
    logic [XY_SZ:0]        res_sinh;

    modport master (
        output req_valid, req_angle,
        input  req_ready, res_valid, res_id, res_cosh, res_sinh
    );

    modport slave (
        input  req_valid, req_angle,
        output req_ready, res_valid, res_id, res_cosh, res_sinh
    );
endinterface

// File: rtl/cordic_hyp_sched.sv
// Round-robin scheduler sharing one fixed-latency hyperbolic CORDIC between
// NUM_REQ requesters, with a tag pipe to route results and a pause/drain FSM.
//
// state   | meaning
// S_IDLE  | quiescent; first valid request (without pause) is granted and moves to S_RUN
// S_RUN   | granting one request per cycle round-robin
// S_DRAIN | paused; no grants, waits for in-flight ops and pause release
module cordic_hyp_sched #(
    parameter int               NUM_REQ = 4,
    parameter int               XY_SZ   = 16,
    parameter int               LAT     = 16,
    parameter logic [XY_SZ-1:0] X_INIT  = 16'h26A3,
    parameter logic [XY_SZ-1:0] Y_INIT  = 16'h0000
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pause,
    cordic_hyp_sched_if.slave            bus,
    output logic [31:0]                  cordic_angle,
    output logic [XY_SZ-1:0]             cordic_x,
    output logic [XY_SZ-1:0]             cordic_y,
    input  logic [XY_SZ:0]               cordic_xout,
    input  logic [XY_SZ:0]               cordic_yout,
    output logic [$clog2(LAT+2)-1:0]     inflight,
    output logic                         idle
);
    localparam int ID_W = $clog2(NUM_REQ);
    localparam int IF_W = $clog2(LAT+2);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t          state;
    logic [ID_W-1:0] rr_ptr;
    logic [LAT:0]    tag_v;
    logic [ID_W-1:0] tag_id [0:LAT];

    logic            grant_en;
    logic            sel_found;
    logic [ID_W-1:0] sel_id;
    logic [ID_W-1:0] idx;
    logic [31:0]     sel_angle;
    logic            accept;

    // IDLE only grants when a request is present, which sel_found already implies
    assign grant_en = !rst && !pause && (state != S_DRAIN);

    always_comb begin
        sel_found = 1'b0;
        sel_id    = '0;
        sel_angle = '0;
        idx       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ID_W'((int'(rr_ptr) + i) % NUM_REQ);
            if (!sel_found && bus.req_valid[idx]) begin
                sel_found = 1'b1;
                sel_id    = idx;
                sel_angle = bus.req_angle[32*idx +: 32];
            end
        end
    end

    assign accept        = grant_en && sel_found;
    assign bus.req_ready = accept ? (NUM_REQ'(1) << sel_id) : '0;

    assign bus.res_valid = tag_v[LAT];
    assign bus.res_id    = tag_id[LAT];
    assign bus.res_cosh  = tag_v[LAT] ? cordic_xout : '0;
    assign bus.res_sinh  = tag_v[LAT] ? cordic_yout : '0;
    assign idle          = (state == S_IDLE) && (inflight == '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_IDLE;
            rr_ptr       <= '0;
            cordic_angle <= '0;
            cordic_x     <= '0;
            cordic_y     <= '0;
            tag_v        <= '0;
            inflight     <= '0;
            for (int k = 0; k <= LAT; k++) tag_id[k] <= '0;
        end else begin
            case (state)
                S_IDLE:  if (!pause && |bus.req_valid) state <= S_RUN;
                S_RUN:   if (pause) state <= S_DRAIN;
                S_DRAIN: if (!pause && inflight == '0) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase

            if (accept) begin
                cordic_angle <= sel_angle;
                cordic_x     <= X_INIT;
                cordic_y     <= Y_INIT;
                rr_ptr       <= (sel_id == ID_W'(NUM_REQ-1)) ? '0 : sel_id + 1'b1;
            end

            tag_v <= {tag_v[LAT-1:0], accept};
            for (int k = LAT; k > 0; k--) tag_id[k] <= tag_id[k-1];
            tag_id[0] <= sel_id;

            // the tag pipe bounds inflight at LAT+1, so no saturation is needed
            case ({accept, tag_v[LAT]})
                2'b10:   inflight <= inflight + IF_W'(1);
                2'b01:   inflight <= inflight - IF_W'(1);
                default: inflight <= inflight;
            endcase
        end
    end
endmodule

// File: tb/tb_cordic_hyp_sched.sv
// Randomized bench for cordic_hyp_sched: a queue-based reference model of
// grants, latency and drain behaviour, plus a delay-line stand-in for the CORDIC.
module tb_cordic_hyp_sched;
    localparam int          NUM_REQ = 4;
    localparam int          XY_SZ   = 16;
    localparam int          LAT     = 16;
    localparam logic [15:0] X_INIT  = 16'h26A3;

    logic              clk = 1'b0;
    logic              rst;
    logic              pause;
    logic [31:0]       cordic_angle;
    logic [XY_SZ-1:0]  cordic_x;
    logic [XY_SZ-1:0]  cordic_y;
    logic [XY_SZ:0]    cordic_xout;
    logic [XY_SZ:0]    cordic_yout;
    logic [4:0]        inflight;
    logic              idle;

    always #5 clk = ~clk;

    cordic_hyp_sched_if #(.NUM_REQ(NUM_REQ), .XY_SZ(XY_SZ)) bus ();

    cordic_hyp_sched #(.NUM_REQ(NUM_REQ), .XY_SZ(XY_SZ), .LAT(LAT)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .pause        (pause),
        .bus          (bus),
        .cordic_angle (cordic_angle),
        .cordic_x     (cordic_x),
        .cordic_y     (cordic_y),
        .cordic_xout  (cordic_xout),
        .cordic_yout  (cordic_yout),
        .inflight     (inflight),
        .idle         (idle)
    );

    typedef struct {
        int          id;
        logic [31:0] ang;
        int          due;
    } op_t;

    op_t         pend[$];
    int          m_state;
    int          m_rr;
    logic [31:0] m_angle;
    logic [15:0] m_x;
    logic [31:0] ang_log [0:4095];
    int          cyc;
    int          n_checks;
    int          n_errors;
    int          peak;
    logic        force_ang;
    logic [31:0] forced_ang;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [16:0] f_cosh(input logic [31:0] a);
        return a[16:0] ^ 17'h05A5A;
    endfunction

    function automatic logic [16:0] f_sinh(input logic [31:0] a);
        return a[31:15];
    endfunction

    task automatic step(input logic r, input logic p, input logic [3:0] v);
        logic        gen;
        logic        ret;
        int          g;
        int          k;
        int          n_before;
        logic [3:0]  exp_rdy;
        logic [31:0] a;
        rst           = r;
        pause         = p;
        bus.req_valid = v;
        for (int i = 0; i < NUM_REQ; i++)
            bus.req_angle[32*i +: 32] = force_ang ? forced_ang : $urandom();
        if (cyc >= LAT) begin
            a           = ang_log[(cyc - LAT) % 4096];
            cordic_xout = f_cosh(a);
            cordic_yout = f_sinh(a);
        end else begin
            cordic_xout = '0;
            cordic_yout = '0;
        end

        @(negedge clk);
        gen = !r && !p && (m_state != 2);
        g   = -1;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = (m_rr + i) % NUM_REQ;
            if (g < 0 && v[k]) g = k;
        end
        exp_rdy = (gen && g >= 0) ? 4'(1 << g) : 4'h0;
        check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));

        n_before = pend.size();
        ret      = (n_before > 0) && (pend[0].due == cyc);
        if (!r) begin
            check("res_valid", 64'(bus.res_valid), 64'(ret));
            if (ret) check("res_id", 64'(bus.res_id), 64'(pend[0].id));
            check("res_cosh", 64'(bus.res_cosh), ret ? 64'(f_cosh(pend[0].ang)) : 64'h0);
            check("res_sinh", 64'(bus.res_sinh), ret ? 64'(f_sinh(pend[0].ang)) : 64'h0);
            check("inflight", 64'(inflight), 64'(n_before));
            check("idle", 64'(idle), 64'(m_state == 0 && n_before == 0));
            check("cordic_angle", 64'(cordic_angle), 64'(m_angle));
            check("cordic_x", 64'(cordic_x), 64'(m_x));
            check("cordic_y", 64'(cordic_y), 64'h0);
            if (int'(inflight) > peak) peak = int'(inflight);
        end
        ang_log[cyc % 4096] = cordic_angle;

        if (r) begin
            pend.delete();
            m_state = 0;
            m_rr    = 0;
            m_angle = '0;
            m_x     = '0;
        end else begin
            if (ret) void'(pend.pop_front());
            if (gen && g >= 0) begin
                pend.push_back('{g, bus.req_angle[32*g +: 32], cyc + LAT + 1});
                m_rr    = (g + 1) % NUM_REQ;
                m_angle = bus.req_angle[32*g +: 32];
                m_x     = X_INIT;
            end
            case (m_state)
                0: if (!p && |v) m_state = 1;
                1: if (p) m_state = 2;
                2: if (!p && n_before == 0) m_state = 0;
                default: m_state = 0;
            endcase
        end

        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        logic [3:0] v;
        logic       p;
        logic       r;
        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        m_state    = 0;
        m_rr       = 0;
        m_angle    = '0;
        m_x        = '0;
        peak       = 0;
        force_ang  = 1'b0;
        forced_ang = '0;
        rst        = 1'b1;
        pause      = 1'b0;
        bus.req_valid = '0;
        bus.req_angle = '0;
        cordic_xout   = '0;
        cordic_yout   = '0;
        for (int i = 0; i < 4096; i++) ang_log[i] = '0;
        #1;

        repeat (2) step(1'b1, 1'b0, 4'h0);
        repeat (3) step(1'b0, 1'b0, 4'h0);

        // single op from requester 2
        force_ang  = 1'b1;
        forced_ang = 32'h10000000;
        step(1'b0, 1'b0, 4'b0100);
        force_ang  = 1'b0;
        repeat (25) step(1'b0, 1'b0, 4'h0);

        // round-robin with all requesters
        repeat (8) step(1'b0, 1'b0, 4'hF);
        repeat (20) step(1'b0, 1'b0, 4'h0);

        // full-rate stream from requester 1
        peak = 0;
        repeat (20) step(1'b0, 1'b0, 4'b0010);
        check("inflight_peak", 64'(peak), 64'(LAT + 1));
        repeat (20) step(1'b0, 1'b0, 4'h0);

        // pause with ops in flight, then release
        repeat (5) step(1'b0, 1'b0, 4'hF);
        repeat (30) step(1'b0, 1'b1, 4'hF);
        repeat (4) step(1'b0, 1'b0, 4'h0);

        // reset mid-flight
        repeat (6) step(1'b0, 1'b0, 4'hF);
        step(1'b1, 1'b0, 4'hF);
        repeat (3) step(1'b0, 1'b0, 4'b1010);
        repeat (20) step(1'b0, 1'b0, 4'h0);

        repeat (800) begin
            v = 4'($urandom());
            p = ($urandom_range(0, 9) == 0);
            r = ($urandom_range(0, 299) == 0);
            step(r, p, v);
        end
        repeat (LAT + 4) step(1'b0, 1'b0, 4'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/cordic_hyp_sched.md
Name: cordic_hyp_sched

Overview:
- Shares one pipelined hyperbolic CORDIC instance (sinh/cosh rotation mode, no stall input, fixed latency) between NUM_REQ activation-function requesters.
- Arbitrates round-robin, drives the CORDIC inputs from registers, and tracks in-flight operations with a tag shift pipeline so each result is routed back with its requester id.
- Provides a pause/drain FSM so upstream control can quiesce the datapath before reconfiguration.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- XY_SZ, 16, CORDIC X/Y input width; CORDIC outputs are XY_SZ+1
- LAT, 16, CORDIC latency in cycles from input register to Xout/Yout valid (equals XY_SZ for the team's CORDIC)
- X_INIT, 16'h26A3, X value loaded on every issue (gain pre-compensation)
- Y_INIT, 16'h0000, Y value loaded on every issue

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- pause  in  1  stop granting new requests; in-flight ops complete
- req_valid  in  NUM_REQ  per-requester request valid
- req_angle  in  32*NUM_REQ  per-requester signed 32-bit angle; requester r occupies bits [32r+31:32r]
- req_ready  out  NUM_REQ  one-hot grant; handshake when valid&ready
- cordic_angle  out  32  to CORDIC angle
- cordic_x  out  XY_SZ  to CORDIC Xin
- cordic_y  out  XY_SZ  to CORDIC Yin
- cordic_xout  in  XY_SZ+1  from CORDIC Xout (cosh)
- cordic_yout  in  XY_SZ+1  from CORDIC Yout (sinh)
- res_valid  out  1  result valid, single cycle, no backpressure
- res_id  out  clog2(NUM_REQ)  requester index of result
- res_cosh  out  XY_SZ+1  = cordic_xout when res_valid, else 0
- res_sinh  out  XY_SZ+1  = cordic_yout when res_valid, else 0
- inflight  out  clog2(LAT+2)  number of accepted ops not yet returned
- idle  out  1  state IDLE and inflight==0

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst).
- Reset: req_ready=0, cordic_angle=0, cordic_x=0, cordic_y=0, all tag-pipe valids cleared, res_valid=0, res_id=0, inflight=0, state=IDLE, RR pointer=0, idle=1. Reset mid-operation discards all in-flight tags; the CORDIC pipeline contents that emerge afterwards are ignored.
- FSM states:
  - IDLE: entered from reset. Goes to RUN when !pause and any req_valid.
  - RUN: grants allowed. Goes to DRAIN when pause=1.
  - DRAIN: no grants. Goes to IDLE when inflight==0 and pause=0. Stays in DRAIN while pause=1, even if inflight==0; idle=1 only in IDLE.
- Grants are allowed only in RUN, and in IDLE in the cycle the IDLE->RUN condition holds.
- Arbitration:
  - req_ready is combinational and one-hot.
  - The grant goes to the first requester with req_valid=1 searching upward from the RR pointer, wrapping mod NUM_REQ.
  - One accept per cycle at most.
  - On accept of requester g, RR pointer <= (g+1) mod NUM_REQ; otherwise the pointer holds.
  - A requester that keeps req_valid high is served at least once every NUM_REQ accepts.
- Issue: on the accept edge, cordic_angle <= selected angle, cordic_x <= X_INIT, cordic_y <= Y_INIT, and tag {1,g} enters the tag pipe. With no accept, the CORDIC input registers hold their values and an invalid tag enters.
- Tag pipe: LAT+1 stages of {valid,id} that shift every cycle. res_valid and res_id are the tail stage.
- Latency: a handshake in cycle c gives res_valid=1 in cycle c+LAT+1, with res_cosh/res_sinh taken from the CORDIC outputs in that cycle.
- Throughput: one op per cycle sustained.
- inflight increments on accept and decrements on res_valid. A simultaneous accept and return leaves it unchanged. Maximum value is LAT+1, and it never wraps.
- pause asserted in the same cycle as a would-be grant: no grant that cycle.
- The angle range restriction of the CORDIC (|angle| within convergence) is the requester's responsibility; the scheduler does not check it.

Test Plan:
- Single op: after reset, req_valid[2]=1, angle=32'h10000000 in cycle 5 -> req_ready=4'b0100 in cycle 5; cordic_angle=32'h10000000 and cordic_x=16'h26A3 from cycle 6; res_valid=1, res_id=2 in cycle 22 (LAT=16); inflight 1 during cycles 6..22 and 0 at cycle 23.
- Round-robin: all four req_valid held high for 8 cycles -> grant order 0,1,2,3,0,1,2,3; res_id sequence identical 17 cycles later; inflight peaks at 8.
- Back-to-back full rate: requester 1 only, valid for 20 cycles -> 20 consecutive res_valid cycles; inflight saturates at 17 and never exceeds LAT+1.
- Pause/drain: pause=1 while 5 ops in flight -> req_ready=0 immediately; 5 results still return; state stays DRAIN with idle=0 until pause=0, then IDLE and idle=1 the next cycle.
- Reset mid-flight: rst=1 for 1 cycle with 6 ops in flight -> no res_valid for the next LAT+1 cycles; inflight=0; RR pointer=0, so the first grant goes to the lowest valid requester.
- Simultaneous accept and return: a steady stream gives an accept in the same cycle as res_valid -> inflight unchanged.
